// File: rtl/aes_cipher_serializer_if.sv
// rtl/aes_cipher_serializer_if.sv - word stream bundle between the serializer and its consumer
interface aes_cipher_serializer_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (output m_data, m_valid, m_last, input m_ready);
  modport slave  (input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/aes_cipher_serializer.sv
// rtl/aes_cipher_serializer.sv - buffers 128-bit AES result blocks and streams them as WORD_W-bit words
module aes_cipher_serializer #(
  parameter int WORD_W    = 32,
  parameter int DEPTH     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_out,
  input  logic [127:0]               cipher_text,
  aes_cipher_serializer_if.master    m,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       overflow
);
  localparam int NWORDS = 128 / WORD_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int IW     = $clog2(NWORDS);
  localparam int FILL_W = AW + 1;
  localparam logic [IW-1:0]     LAST_IDX  = IW'(NWORDS - 1);
  localparam logic [FILL_W-1:0] DEPTH_VAL = FILL_W'(DEPTH);

  logic [127:0]      mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     sel;
  logic [127:0]      head;
  logic [WORD_W-1:0] words [NWORDS];
  logic              xfer;
  logic              pop;
  logic              push;

  assign xfer = m.m_valid & m.m_ready;
  assign pop  = xfer & (idx == LAST_IDX);
  // A full buffer still takes a block when the head leaves on the same edge.
  assign push = valid_out & ((fill < DEPTH_VAL) | pop);

  assign m.m_valid = (fill != '0);
  assign m.m_last  = m.m_valid & (idx == LAST_IDX);

  always_comb begin
    head = mem[rd_ptr];
    for (int i = 0; i < NWORDS; i++) begin
      words[i] = head[i*WORD_W +: WORD_W];
    end
    if (MSB_FIRST) sel = LAST_IDX - idx;
    else           sel = idx;
  end

  // Gated so stale buffer contents never show while nothing is held.
  assign m.m_data = m.m_valid ? words[sel] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cipher_text;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      idx      <= '0;
      fill     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (valid_out && !push) overflow <= 1'b1;
      if (xfer) idx <= pop ? '0 : idx + IW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end
endmodule
